stage_mem: RTL and testbench

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem.sv | 120 ++++++++++++
 tb/tb_stage_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// MEM pipeline stage: 256x32 data memory with WR-to-MEM store-data forwarding
// and the MEM/WR pipeline register (stall holds, flush inserts a bubble).
module stage_mem (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEMin_ALUout,
  input  logic [31:0] MEMin_BusB,
  input  logic [4:0]  MEMin_Rt,
  input  logic [4:0]  MEMin_Rw,
  input  logic        MEMin_Overflow,
  input  logic        MEMin_MemWr,
  input  logic        MEMin_MemtoReg,
  input  logic        MEMin_RegWr,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] WRfwd_RegDin,
  input  logic [4:0]  WRfwd_Rw,
  input  logic        WRfwd_RegWE,
  output logic [31:0] MEMout_Dout,
  output logic [31:0] MEMout_ALUout,
  output logic [4:0]  MEMout_Rw,
  output logic        MEMout_Overflow,
  output logic        MEMout_MemtoReg,
  output logic        MEMout_RegWr,
  output logic        MEMout_AddrErr
);

  logic [31:0] mem [256];

  logic [7:0]  idx;
  logic        aligned;
  logic        fwd_hit;
  logic [31:0] st_data;
  logic        mem_we;

  logic [31:0] dout_q;
  logic [31:0] alu_q,   alu_d;
  logic [4:0]  rw_q,    rw_d;
  logic        ovf_q,   ovf_d;
  logic        mtr_q,   mtr_d;
  logic        regwr_q, regwr_d;
  logic        aerr_q,  aerr_d;

  always_comb begin
    idx     = MEMin_ALUout[9:2];
    aligned = (MEMin_ALUout[1:0] == 2'b00);
    fwd_hit = WRfwd_RegWE && (WRfwd_Rw != 5'd0) && (WRfwd_Rw == MEMin_Rt);
    st_data = fwd_hit ? WRfwd_RegDin : MEMin_BusB;
    mem_we  = MEMin_MemWr && !MEMin_Overflow && aligned && !Stall && !Flush;
  end

  always_comb begin
    alu_d   = alu_q;
    rw_d    = rw_q;
    ovf_d   = ovf_q;
    mtr_d   = mtr_q;
    regwr_d = regwr_q;
    aerr_d  = aerr_q;
    if (Flush) begin
      alu_d   = '0;
      rw_d    = '0;
      ovf_d   = 1'b0;
      mtr_d   = 1'b0;
      regwr_d = 1'b0;
      aerr_d  = 1'b0;
    end else if (!Stall) begin
      alu_d   = MEMin_ALUout;
      rw_d    = MEMin_Rw;
      ovf_d   = MEMin_Overflow;
      mtr_d   = MEMin_MemtoReg;
      // A misaligned load must not reach the register file.
      regwr_d = MEMin_RegWr && !(MEMin_MemtoReg && !aligned);
      aerr_d  = !aligned && (MEMin_MemWr || MEMin_MemtoReg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      rw_q    <= '0;
      ovf_q   <= 1'b0;
      mtr_q   <= 1'b0;
      regwr_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      rw_q    <= rw_d;
      ovf_q   <= ovf_d;
      mtr_q   <= mtr_d;
      regwr_q <= regwr_d;
      aerr_q  <= aerr_d;
    end
  end

  // Memory lives under the reset branch only so an edge seen during reset
  // cannot write; its contents are never cleared. Read-before-write via NBA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      if (mem_we) begin
        mem[idx] <= st_data;
      end
      if (Flush) begin
        dout_q <= '0;
      end else if (!Stall) begin
        dout_q <= mem[idx];
      end
    end
  end

  assign MEMout_Dout     = dout_q;
  assign MEMout_ALUout   = alu_q;
  assign MEMout_Rw       = rw_q;
  assign MEMout_Overflow = ovf_q;
  assign MEMout_MemtoReg = mtr_q;
  assign MEMout_RegWr    = regwr_q;
  assign MEMout_AddrErr  = aerr_q;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed scenarios plus random traffic checked against
// a word-array memory model and a per-cycle expected MEM/WR register image.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu, busb, fdin;
  logic [4:0]  rt, rw, frw;
  logic        ovf, memwr, mtr, regwr, stall, flush, fwe;
  logic [31:0] o_dout, o_alu;
  logic [4:0]  o_rw;
  logic        o_ovf, o_mtr, o_regwr, o_aerr;

  int errors = 0;
  int checks = 0;

  // Reference state: memory words with a written flag, and expected outputs.
  logic [31:0] m_mem [256];
  bit          m_ok  [256];
  logic [31:0] e_dout, e_alu;
  logic [4:0]  e_rw;
  logic        e_ovf, e_mtr, e_regwr, e_aerr;
  bit          e_dout_ok;

  stage_mem dut (
    .clk(clk), .rst_n(rst_n),
    .MEMin_ALUout(alu), .MEMin_BusB(busb), .MEMin_Rt(rt), .MEMin_Rw(rw),
    .MEMin_Overflow(ovf), .MEMin_MemWr(memwr), .MEMin_MemtoReg(mtr),
    .MEMin_RegWr(regwr), .Stall(stall), .Flush(flush),
    .WRfwd_RegDin(fdin), .WRfwd_Rw(frw), .WRfwd_RegWE(fwe),
    .MEMout_Dout(o_dout), .MEMout_ALUout(o_alu), .MEMout_Rw(o_rw),
    .MEMout_Overflow(o_ovf), .MEMout_MemtoReg(o_mtr),
    .MEMout_RegWr(o_regwr), .MEMout_AddrErr(o_aerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    if (e_dout_ok) chk({tag, "_dout"}, o_dout, e_dout);
    chk({tag, "_alu"},   o_alu,          e_alu);
    chk({tag, "_rw"},    {27'd0, o_rw},  {27'd0, e_rw});
    chk({tag, "_ovf"},   {31'd0, o_ovf},   {31'd0, e_ovf});
    chk({tag, "_mtr"},   {31'd0, o_mtr},   {31'd0, e_mtr});
    chk({tag, "_regwr"}, {31'd0, o_regwr}, {31'd0, e_regwr});
    chk({tag, "_aerr"},  {31'd0, o_aerr},  {31'd0, e_aerr});
  endtask

  task automatic clr();
    alu = '0; busb = '0; rt = '0; rw = '0; ovf = 0; memwr = 0; mtr = 0;
    regwr = 0; stall = 0; flush = 0; fdin = '0; frw = '0; fwe = 0;
  endtask

  task automatic zero_expect();
    e_dout = '0; e_alu = '0; e_rw = '0; e_ovf = 0; e_mtr = 0;
    e_regwr = 0; e_aerr = 0; e_dout_ok = 1;
  endtask

  // One clock of the stage: model the edge from the current inputs, then check.
  task automatic cycle(input string tag);
    int  a;
    bit  al, wr;
    logic [31:0] sd;
    a  = int'(alu % 1024) / 4;
    al = (alu % 4) == 0;
    sd = (fwe && frw != 0 && frw == rt) ? fdin : busb;
    wr = memwr && !ovf && al && !stall && !flush;
    @(posedge clk);
    if (flush) begin
      zero_expect();
    end else if (!stall) begin
      e_dout    = m_mem[a];
      e_dout_ok = m_ok[a];
      e_alu     = alu;
      e_rw      = rw;
      e_ovf     = ovf;
      e_mtr     = mtr;
      e_regwr   = regwr && !(mtr && !al);
      e_aerr    = !al && (memwr || mtr);
    end
    if (wr) begin
      m_mem[a] = sd;
      m_ok[a]  = 1;
    end
    @(negedge clk);
    $display("%s alu=%h wr=%0d st=%0d fl=%0d -> dout=%h rw=%0d regwr=%0d aerr=%0d",
             tag, alu, memwr, stall, flush, o_dout, o_rw, o_regwr, o_aerr);
    check_all(tag);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
    clr(); alu = a; busb = d; memwr = 1; rt = 5'd3;
    cycle(tag);
  endtask

  task automatic load(input logic [31:0] a, input string tag);
    clr(); alu = a; mtr = 1; regwr = 1; rw = 5'd9;
    cycle(tag);
  endtask

  initial begin
    foreach (m_ok[i]) m_ok[i] = 0;
    clr();
    rst_n = 0;
    zero_expect();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;

    for (int i = 0; i < 256; i++) store(i * 4, $urandom, "fill");

    // Basic store then load.
    store(32'h10, 32'hDEADBEEF, "st10");
    load(32'h10, "ld10");
    chk("r029_dout", o_dout, 32'hDEADBEEF);
    chk("r029_mtr", {31'd0, o_mtr}, 32'd1);

    // Forwarding from WR, then Rw=0 disables it.
    clr(); alu = 32'h20; busb = 32'h1; rt = 5; memwr = 1;
    fwe = 1; frw = 5; fdin = 32'h55; cycle("fwd");
    load(32'h20, "ldfwd");
    chk("r030_fwd", o_dout, 32'h55);
    clr(); alu = 32'h20; busb = 32'h1; rt = 0; memwr = 1;
    fwe = 1; frw = 0; fdin = 32'h55; cycle("nofwd");
    load(32'h20, "ldnofwd");
    chk("r030_nofwd", o_dout, 32'h1);

    // Address wrap and misaligned store.
    store(32'h410, 32'hA5A5_0001, "stwrap");
    load(32'h010, "ldwrap");
    chk("r031_wrap", o_dout, 32'hA5A5_0001);
    store(32'h12, 32'h0BAD_0BAD, "stmis");
    chk("r031_aerr", {31'd0, o_aerr}, 32'd1);
    load(32'h10, "ldmis");
    chk("r031_keep", o_dout, 32'hA5A5_0001);
    clr(); alu = 32'h13; mtr = 1; regwr = 1; rw = 7; cycle("ldmisal");

    // Stall for two cycles, then flush with stall.
    clr(); alu = 32'h30; busb = 32'h1111_2222; memwr = 1; stall = 1;
    cycle("stall1"); cycle("stall2");
    chk("r032_hold", o_alu, 32'h13);
    flush = 1; cycle("flush");
    chk("r032_bubble", o_alu | {27'd0, o_rw} | o_dout, 32'd0);
    load(32'h30, "ldstall");

    // Overflow suppresses the store and is passed through.
    store(32'h40, 32'h7777_7777, "st40");
    clr(); alu = 32'h40; busb = 32'h8888_8888; memwr = 1; ovf = 1; cycle("stovf");
    load(32'h40, "ld40");
    chk("r033_keep", o_dout, 32'h7777_7777);
    clr(); alu = 32'h44; ovf = 1; regwr = 1; rw = 4; cycle("aluovf");
    chk("r033_ovf", {31'd0, o_ovf}, 32'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      clr();
      alu   = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      busb  = $urandom;
      rt    = 5'($urandom_range(0, 7));
      rw    = 5'($urandom_range(0, 31));
      frw   = 5'($urandom_range(0, 7));
      fwe   = 1'($urandom_range(0, 1));
      fdin  = $urandom;
      memwr = 1'($urandom_range(0, 1));
      mtr   = !memwr && ($urandom_range(0, 1) == 1);
      regwr = 1'($urandom_range(0, 1));
      ovf   = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    // Reset asserted mid-cycle while a store is presented.
    store(32'h80, 32'hCAFE_F00D, "st80");
    clr(); alu = 32'h80; busb = 32'h1234_5678; memwr = 1; regwr = 1; rw = 3;
    #2 rst_n = 0;
    #1;
    zero_expect();
    check_all("rstasync");
    @(posedge clk);
    @(negedge clk);
    check_all("rsthold");
    rst_n = 1;
    load(32'h80, "ldrst");
    chk("r034_nowrite", o_dout, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
